mips_multicycle_control: RTL and testbench

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_multicycle_control.sv | 122 ++++++++++++
 tb/tb_mips_multicycle_control.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM; define MIPS_CTRL_JUMP_EN to enable the j instruction
module mips_multicycle_control #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [5:0]  alu_func,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_count
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK} state_t;
  localparam logic [5:0] OP_R = 6'd0, OP_LW = 6'd35, OP_SW = 6'd43, OP_BEQ = 6'd4, OP_ADDI = 6'd8, OP_J = 6'd2;
  state_t state_q, state_d;
  logic [5:0] op_q, fn_q;
  logic [3:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d, retire, fn_ok, is_j, legal;
  logic [31:0] instr_count_q;
  assign fn_ok = funct == 6'd32 || funct == 6'd34 || funct == 6'd36 || funct == 6'd37 || funct == 6'd42;
`ifdef MIPS_CTRL_JUMP_EN
  assign is_j = opcode == OP_J;
`else
  assign is_j = 1'b0;
`endif
  assign legal = (opcode == OP_R && fn_ok) || opcode == OP_LW || opcode == OP_SW || opcode == OP_BEQ
              || opcode == OP_ADDI || is_j;
  always_comb begin
    state_d = FETCH;
    cnt_d = cnt_q;
    illegal_d = illegal_q;
    retire = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = 2'd0;
    alu_func = 6'd0;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        illegal_d = illegal_q | ~legal;
        pc_write = legal & is_j;
        pc_src = (legal & is_j) ? 2'd2 : 2'd0;
        retire = legal & is_j;
        state_d = (legal && !is_j) ? EXECUTE : FETCH;
      end
      EXECUTE: begin
        alu_func = op_q == OP_R ? fn_q : op_q == OP_BEQ ? 6'd34 : 6'd32;
        alu_src_b = op_q != OP_R && op_q != OP_BEQ;
        pc_src = op_q == OP_BEQ ? 2'd1 : 2'd0;
        pc_write = op_q == OP_BEQ && zero;
        retire = op_q == OP_BEQ;
        cnt_d = 4'(MEM_LATENCY - 1);
        state_d = op_q == OP_BEQ ? FETCH : (op_q == OP_LW || op_q == OP_SW) ? MEM : WRITEBACK;
      end
      MEM: begin
        alu_func = 6'd32;
        alu_src_b = 1'b1;
        mem_read = op_q == OP_LW;
        mem_write = op_q == OP_SW;
        cnt_d = cnt_q - 4'd1;
        retire = cnt_q == 4'd0 && op_q == OP_SW;
        state_d = cnt_q != 4'd0 ? MEM : op_q == OP_LW ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        reg_dst = op_q == OP_R;
        mem_to_reg = op_q == OP_LW;
        retire = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // the state register already reads FETCH during reset, so strobes must be masked explicitly
    if (rst) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_src = 2'd0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      op_q <= 6'd0;
      fn_q <= 6'd0;
      cnt_q <= 4'd0;
      illegal_q <= 1'b0;
      instr_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      illegal_q <= illegal_d;
      if (retire) instr_count_q <= instr_count_q + 32'd1;
      if (state_q == DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end
  assign state = state_q;
  assign illegal = illegal_q;
  assign instr_count = instr_count_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed checks of the multicycle control FSM with MEM_LATENCY=3
module tb_mips_multicycle_control;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic ir_write, pc_write, alu_src_b, reg_write, reg_dst, mem_to_reg, mem_read, mem_write, illegal;
  logic [1:0] pc_src;
  logic [5:0] alu_func;
  logic [2:0] state;
  logic [31:0] instr_count;
  int tests = 0, fails = 0;
  mips_multicycle_control #(.MEM_LATENCY(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_func(alu_func),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .mem_read(mem_read), .mem_write(mem_write), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step;
    step;
    chk("rst_state", state, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_illegal", illegal, 0);
    rst = 1'b0;
    opcode = 6'd0; funct = 6'd32;
    #1;
    chk("add_fetch_state", state, 0);
    chk("add_fetch_ir", ir_write, 1);
    chk("add_fetch_pc", pc_write, 1);
    chk("add_fetch_src", pc_src, 0);
    step;
    chk("add_dec_state", state, 1);
    chk("add_dec_ir", ir_write, 0);
    chk("add_dec_alu", alu_func, 0);
    step;
    chk("add_ex_state", state, 2);
    chk("add_ex_alu", alu_func, 32);
    chk("add_ex_srcb", alu_src_b, 0);
    chk("add_ex_rw", reg_write, 0);
    step;
    chk("add_wb_state", state, 4);
    chk("add_wb_rw", reg_write, 1);
    chk("add_wb_dst", reg_dst, 1);
    chk("add_wb_m2r", mem_to_reg, 0);
    chk("add_wb_alu", alu_func, 0);
    step;
    chk("add_done_state", state, 0);
    chk("add_done_count", instr_count, 1);
    opcode = 6'd35; funct = 6'd0;
    step;
    step;
    chk("lw_ex_alu", alu_func, 32);
    chk("lw_ex_srcb", alu_src_b, 1);
    chk("lw_ex_mr", mem_read, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("lw_mem_state", state, 3);
      chk("lw_mem_rd", mem_read, 1);
      chk("lw_mem_wr", mem_write, 0);
      chk("lw_mem_alu", alu_func, 32);
    end
    step;
    chk("lw_wb_state", state, 4);
    chk("lw_wb_rd", mem_read, 0);
    chk("lw_wb_m2r", mem_to_reg, 1);
    chk("lw_wb_dst", reg_dst, 0);
    chk("lw_wb_rw", reg_write, 1);
    step;
    chk("lw_done_state", state, 0);
    chk("lw_done_count", instr_count, 2);
    opcode = 6'd4; zero = 1'b1;
    step;
    step;
    chk("beq1_ex_alu", alu_func, 34);
    chk("beq1_ex_srcb", alu_src_b, 0);
    chk("beq1_ex_pcw", pc_write, 1);
    chk("beq1_ex_src", pc_src, 1);
    step;
    chk("beq1_done_state", state, 0);
    chk("beq1_done_count", instr_count, 3);
    zero = 1'b0;
    step;
    step;
    chk("beq0_ex_pcw", pc_write, 0);
    chk("beq0_ex_src", pc_src, 1);
    step;
    chk("beq0_done_state", state, 0);
    chk("beq0_done_count", instr_count, 4);
    opcode = 6'd63;
    step;
    chk("ill63_dec_illegal", illegal, 0);
    step;
    chk("ill63_state", state, 0);
    chk("ill63_illegal", illegal, 1);
    chk("ill63_count", instr_count, 4);
    opcode = 6'd0; funct = 6'd0;
    step;
    step;
    chk("illfn_state", state, 0);
    chk("illfn_illegal", illegal, 1);
    chk("illfn_count", instr_count, 4);
    opcode = 6'd2;
    step;
    chk("j_dec_pcw", pc_write, 0);
    chk("j_dec_src", pc_src, 0);
    step;
    chk("j_state", state, 0);
    chk("j_count", instr_count, 4);
    opcode = 6'd43;
    step;
    step;
    step;
    chk("sw_mem1_wr", mem_write, 1);
    chk("sw_mem1_rd", mem_read, 0);
    chk("sw_mem1_rw", reg_write, 0);
    step;
    chk("sw_mem2_wr", mem_write, 1);
    rst = 1'b1;
    #1;
    chk("sw_rst_wr", mem_write, 0);
    chk("sw_rst_state", state, 0);
    chk("sw_rst_count", instr_count, 0);
    chk("sw_rst_illegal", illegal, 0);
    step;
    chk("sw_rst_ir", ir_write, 0);
    rst = 1'b0;
    step;
    step;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("sw2_mem_state", state, 3);
      chk("sw2_mem_wr", mem_write, 1);
    end
    step;
    chk("sw2_done_state", state, 0);
    chk("sw2_done_wr", mem_write, 0);
    chk("sw2_done_count", instr_count, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
